// File: rtl/alu_rr_sched.sv
// Round-robin front end for one shared combinational ALU: two requesters take turns,
// each operation is held on registered ALU inputs for its settle latency, then returned.
module alu_rr_sched #(
  parameter int WIDTH   = 16,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 4
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_fun,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_fun,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,

  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_fun,
  input  logic [WIDTH-1:0] alu_out,
  input  logic [3:0]       alu_flags,

  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic [3:0]       rsp_flags,
  output logic             rsp_err
);

  localparam logic [3:0] FUN_MUL = 4'b0010;
  localparam logic [3:0] FUN_DIV = 4'b0011;
  localparam logic [3:0] FUN_NOP = 4'b1111;
  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             accept;
  logic             grant_id;
  logic [3:0]       sel_fun;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [CNT_W-1:0] op_lat;
  logic             exec_last;
  logic             err_div0;
  logic             err_nop;

  // Rejected operations settle in a single cycle regardless of opcode.
  function automatic logic [CNT_W-1:0] latency_of(input logic [3:0] fun,
                                                  input logic [WIDTH-1:0] b);
    logic [CNT_W-1:0] lat;
    lat = CNT_W'(1);
    if (fun == FUN_MUL) begin
      lat = CNT_W'(MUL_LAT);
    end else if (fun == FUN_DIV && b != '0) begin
      lat = CNT_W'(DIV_LAT);
    end
    return lat;
  endfunction

  always_comb begin
    req0_ready = (state_q == IDLE) && req0_valid && (!ptr_q || !req1_valid);
    req1_ready = (state_q == IDLE) && req1_valid && ( ptr_q || !req0_valid);
  end

  always_comb begin
    accept   = req0_ready || req1_ready;
    grant_id = req1_ready;
    sel_fun  = grant_id ? req1_fun : req0_fun;
    sel_a    = grant_id ? req1_a   : req0_a;
    sel_b    = grant_id ? req1_b   : req0_b;
    op_lat   = latency_of(sel_fun, sel_b);
  end

  always_comb begin
    exec_last = (state_q == EXEC) && (cnt_q == CNT_W'(1));
    err_div0  = (alu_fun == FUN_DIV) && (alu_b == '0);
    err_nop   = (alu_fun == FUN_NOP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = EXEC;
          ptr_d   = ~grant_id;
          cnt_d   = op_lat;
        end
      end
      EXEC: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (exec_last) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ALU inputs only change on acceptance, so they stay stable through EXEC and afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_fun <= FUN_NOP;
      rsp_id  <= 1'b0;
    end else if (accept) begin
      alu_a   <= sel_a;
      alu_b   <= sel_b;
      alu_fun <= sel_fun;
      rsp_id  <= grant_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_flags <= '0;
      rsp_err   <= 1'b0;
    end else if (exec_last) begin
      rsp_valid <= 1'b1;
      if (err_div0) begin
        rsp_data  <= '1;
        rsp_flags <= 4'b1000;
        rsp_err   <= 1'b1;
      end else if (err_nop) begin
        rsp_data  <= '0;
        rsp_flags <= 4'b0000;
        rsp_err   <= 1'b1;
      end else begin
        rsp_data  <= alu_out;
        rsp_flags <= alu_flags;
        rsp_err   <= 1'b0;
      end
    end else if (state_q == RESP && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_rr_sched.sv
// Scoreboard bench for alu_rr_sched: a behavioural ALU drives the shared-ALU port,
// a queue of expected responses is filled on every handshake and drained by a monitor.
module tb_alu_rr_sched;

  localparam int WIDTH   = 16;
  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]       req0_fun, req1_fun;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [WIDTH-1:0] alu_a, alu_b, alu_out;
  logic [3:0]       alu_fun, alu_flags;
  logic             rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [WIDTH-1:0] rsp_data;
  logic [3:0]       rsp_flags;

  typedef struct {
    bit          id;
    logic [15:0] data;
    logic [3:0]  flags;
    bit          err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  int          n_pass = 0;
  int          n_total = 0;
  int          cyc = 0;
  bit          busy;
  bit          ptr_m;
  bit          prev_v;
  logic [15:0] prev_data, cap_a, cap_b;
  logic [3:0]  prev_flags, cap_f;
  bit          prev_id, prev_err;

  always #5 clk = ~clk;

  alu_rr_sched #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_fun(req0_fun),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_fun(req1_fun),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun),
    .alu_out(alu_out), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_flags(rsp_flags), .rsp_err(rsp_err)
  );

  // Behavioural ALU: {flags, result}, flags = {Arith, Logic, CMP, Shift}.
  function automatic logic [19:0] alu_ref(input logic [3:0] f, input logic [15:0] a,
                                          input logic [15:0] b);
    logic [15:0] r;
    logic [3:0]  fl;
    logic [31:0] p;
    r  = '0;
    fl = '0;
    p  = {16'b0, a} * {16'b0, b};
    case (f)
      4'b0000: begin r = a + b;                 fl = 4'b1000; end
      4'b0001: begin r = a - b;                 fl = 4'b1000; end
      4'b0010: begin r = p[15:0];               fl = 4'b1000; end
      4'b0011: begin r = (b != 0) ? a / b : '0; fl = 4'b1000; end
      4'b0100: begin r = a & b;                 fl = 4'b0100; end
      4'b0101: begin r = a | b;                 fl = 4'b0100; end
      4'b0110: begin r = a ^ b;                 fl = 4'b0100; end
      4'b0111: begin r = {15'b0, a < b};        fl = 4'b0010; end
      4'b1000: begin r = a << b[3:0];           fl = 4'b0001; end
      4'b1001: begin r = a >> b[3:0];           fl = 4'b0001; end
      default: begin r = '0;                    fl = 4'b0000; end
    endcase
    return {fl, r};
  endfunction

  always_comb {alu_flags, alu_out} = alu_ref(alu_fun, alu_a, alu_b);

  function automatic exp_t model(input bit id, input logic [3:0] f, input logic [15:0] a,
                                 input logic [15:0] b, input int acc);
    exp_t e;
    e.id  = id;
    e.acc = acc;
    e.err = 1'b0;
    e.lat = (f == 4'b0010) ? MUL_LAT : (f == 4'b0011) ? DIV_LAT : 1;
    {e.flags, e.data} = alu_ref(f, a, b);
    if (f == 4'b0011 && b == 0) begin
      e.err = 1'b1; e.data = 16'hFFFF; e.flags = 4'b1000; e.lat = 1;
    end
    if (f == 4'b1111) begin
      e.err = 1'b1; e.data = 16'h0000; e.flags = 4'b0000; e.lat = 1;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: grant model, ALU-input hold, response scoreboard, handshake capture.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      sb.delete();
      busy = 0; ptr_m = 0; prev_v = 0;
      cap_a = '0; cap_b = '0; cap_f = 4'hF;
    end else begin
      if (req0_valid || req1_valid || req0_ready || req1_ready) begin
        chk("req0_ready", req0_ready, !busy && req0_valid && (!ptr_m || !req1_valid));
        chk("req1_ready", req1_ready, !busy && req1_valid && ( ptr_m || !req0_valid));
      end
      chk("alu_a_hold", alu_a, cap_a);
      chk("alu_b_hold", alu_b, cap_b);
      chk("alu_fun_hold", alu_fun, cap_f);
      if (rsp_valid) begin
        if (!prev_v) begin
          chk("rsp_expected", sb.size() != 0, 1);
          if (sb.size() != 0) begin
            chk("rsp_id", rsp_id, sb[0].id);
            chk("rsp_data", rsp_data, sb[0].data);
            chk("rsp_flags", rsp_flags, sb[0].flags);
            chk("rsp_err", rsp_err, sb[0].err);
            chk("rsp_latency", cyc - sb[0].acc, sb[0].lat);
          end
        end else begin
          chk("rsp_data_stable", rsp_data, prev_data);
          chk("rsp_id_stable", rsp_id, prev_id);
          chk("rsp_flags_stable", rsp_flags, prev_flags);
          chk("rsp_err_stable", rsp_err, prev_err);
        end
        if (rsp_ready) begin
          if (sb.size() != 0) void'(sb.pop_front());
          busy = 0;
        end
      end
      prev_v = rsp_valid; prev_data = rsp_data; prev_id = rsp_id;
      prev_flags = rsp_flags; prev_err = rsp_err;
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
        if (req1_ready) begin
          sb.push_back(model(1'b1, req1_fun, req1_a, req1_b, cyc + 1));
          cap_a = req1_a; cap_b = req1_b; cap_f = req1_fun;
        end else begin
          sb.push_back(model(1'b0, req0_fun, req0_a, req0_b, cyc + 1));
          cap_a = req0_a; cap_b = req0_b; cap_f = req0_fun;
        end
        busy  = 1;
        ptr_m = !req1_ready;
      end
    end
  end

  // Called at posedge+1; holds VALID and payload until the handshake edge.
  task automatic applyStimulus(input bit id, input logic [3:0] f, input logic [15:0] a,
                               input logic [15:0] b);
    bit got = 0;
    int budget = 0;
    if (id) begin req1_valid = 1; req1_fun = f; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1; req0_fun = f; req0_a = a; req0_b = b; end
    while (!got && budget < 300) begin
      @(negedge clk);
      got = id ? req1_ready : req0_ready;
      budget++;
    end
    chk(id ? "req1_handshake" : "req0_handshake", got, 1);
    @(posedge clk);
    #1;
    if (id) req1_valid = 0; else req0_valid = 0;
  endtask

  task automatic randIssue(input bit id);
    logic [3:0]  f;
    logic [15:0] a, b;
    int          gap;
    f   = 4'($urandom_range(0, 15));
    a   = 16'($urandom);
    b   = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
    gap = $urandom_range(0, 3);
    if (gap > 0) begin
      repeat (gap) @(posedge clk);
      #1;
    end
    applyStimulus(id, f, a, b);
  endtask

  // Waits for the scoreboard to empty, then returns at posedge+1.
  task automatic checkOutput(input string name);
    int budget = 0;
    while (sb.size() != 0 && budget < 400) begin
      @(negedge clk);
      budget++;
    end
    chk(name, sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit drv_done;
    req0_valid = 0; req1_valid = 0;
    req0_fun = '0; req0_a = '0; req0_b = '0;
    req1_fun = '0; req1_a = '0; req1_b = '0;
    rsp_ready = 1;

    @(negedge clk);
    #1;
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_id", rsp_id, 0);
    chk("reset_rsp_data", rsp_data, 0);
    chk("reset_rsp_flags", rsp_flags, 0);
    chk("reset_rsp_err", rsp_err, 0);
    chk("reset_alu_a", alu_a, 0);
    chk("reset_alu_b", alu_b, 0);
    chk("reset_alu_fun", alu_fun, 4'hF);
    @(posedge clk);
    #1;
    rst_n = 1;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] single ADD from requester 0");
    applyStimulus(0, 4'b0000, 16'd3, 16'd4);
    checkOutput("drain_add");

    $display("[TB] both requesters contending");
    fork
      begin applyStimulus(0, 4'b0000, 16'd10, 16'd1); applyStimulus(0, 4'b0000, 16'd20, 16'd2); end
      begin applyStimulus(1, 4'b0000, 16'd30, 16'd3); applyStimulus(1, 4'b0000, 16'd40, 16'd4); end
    join
    checkOutput("drain_contend");

    $display("[TB] divide and divide-by-zero");
    applyStimulus(1, 4'b0011, 16'd100, 16'd7);
    checkOutput("drain_div");
    applyStimulus(1, 4'b0011, 16'd5, 16'd0);
    checkOutput("drain_div0");
    applyStimulus(0, 4'b1111, 16'd9, 16'd9);
    checkOutput("drain_nop");

    $display("[TB] response back-pressure");
    rsp_ready = 0;
    applyStimulus(1, 4'b0001, 16'd50, 16'd8);
    fork
      applyStimulus(0, 4'b0101, 16'h00F0, 16'h0F00);
    join_none
    repeat (10) @(negedge clk);
    @(posedge clk);
    #1;
    rsp_ready = 1;
    @(negedge clk);
    @(negedge clk);
    chk("accept_after_release", req0_ready, 1);
    wait fork;
    checkOutput("drain_backpressure");

    $display("[TB] reset during multiply");
    applyStimulus(1, 4'b0010, 16'd300, 16'd300);
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_rsp_data", rsp_data, 0);
    chk("midrst_rsp_id", rsp_id, 0);
    chk("midrst_alu_a", alu_a, 0);
    chk("midrst_alu_b", alu_b, 0);
    chk("midrst_alu_fun", alu_fun, 4'hF);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1;
    repeat (10) @(posedge clk);
    #1;
    fork
      applyStimulus(1, 4'b0110, 16'hAAAA, 16'h5555);
      applyStimulus(0, 4'b1000, 16'h0001, 16'h0004);
    join
    checkOutput("drain_after_reset");

    $display("[TB] randomized traffic");
    drv_done = 0;
    fork
      begin
        fork
          for (int i = 0; i < 25; i++) randIssue(0);
          for (int j = 0; j < 25; j++) randIssue(1);
        join
        drv_done = 1;
      end
      begin
        while (!drv_done) begin
          @(posedge clk);
          #1;
          rsp_ready = ($urandom_range(0, 3) != 0);
        end
        rsp_ready = 1;
      end
    join
    checkOutput("drain_random");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
